// File: rtl/fifo_warb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_warb_pkg;

    // Arbiter FSM: IDLE arbitrates freely, BURST keeps the current owner.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Width of each per-requester stall counter (saturating).
    localparam int STALL_W = 16;

    // Ceiling log2, never less than 1 so single-bit fields stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin priority picker: first masked request strictly after 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the pick is used.
module rr_pick #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    input  logic [N-1:0]    mask,
    output logic            vld,
    output logic [ID_W-1:0] idx
);

    logic [N-1:0] rm;
    logic [N-1:0] rot;
    int           sum;

    // Rotate so that bit 0 is the requester right after 'last'.
    assign rm  = req & mask;
    assign rot = N'({rm, rm} >> (int'(last) + 1));

    // Lowest set bit of the rotated vector wins; map it back to a real index.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        sum = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                vld = 1'b1;
                sum = int'(last) + 1 + i;
                if (sum >= N) begin
                    sum = sum - N;
                end
                idx = ID_W'(sum);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of one FIFO write port; optional stall counters via FIFO_WARB_STALL_CNT_EN.
// Latency: 1 cycle from combinational o_ack to registered o_wen_ctrl/o_wdata/o_grant_id.
// Backpressure: no ack while FIFO full, or almost full with a write already in flight; requesters hold until acked.
module fifo_write_arbiter
    import fifo_warb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rest_n,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ*DATA_W-1:0]   i_wdata,
    output logic [NUM_REQ-1:0]          o_ack,
    input  logic                        i_full,
    input  logic                        i_almost_full,
    output logic                        o_wen_ctrl,
    output logic [DATA_W-1:0]           o_wdata,
    output logic [$clog2(NUM_REQ)-1:0]  o_grant_id
`ifdef FIFO_WARB_STALL_CNT_EN
    ,
    output logic [NUM_REQ*STALL_W-1:0]  o_stall_cnt
`endif
);

    localparam int ID_W  = clog2(NUM_REQ);
    localparam int CNT_W = clog2(MAX_BURST + 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              can_write;
    logic              arb;
    logic              accept;
    logic [ID_W-1:0]   acc_id;
    logic [ID_W-1:0]   pick_last;
    logic              pick_vld;
    logic [ID_W-1:0]   pick_idx;
    logic [DATA_W-1:0] wsel;

    // Reset is folded in so o_ack drops the moment reset asserts; the
    // almost-full term accounts for the write already registered.
    assign can_write = i_rest_n && !i_full && !(o_wen_ctrl && i_almost_full);

    // On release the outgoing owner becomes 'last', giving it lowest priority.
    assign pick_last = (state_q == ST_BURST) ? owner_q : last_q;

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req  (i_req),
        .last (pick_last),
        .mask ({NUM_REQ{1'b1}}),
        .vld  (pick_vld),
        .idx  (pick_idx)
    );

    // Next-state, burst bookkeeping and same-cycle ack generation.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        arb     = 1'b0;
        accept  = 1'b0;
        acc_id  = owner_q;
        o_ack   = '0;
        case (state_q)
            ST_IDLE: begin
                arb = 1'b1;
            end
            ST_BURST: begin
                if (i_req[owner_q] && (cnt_q < CNT_W'(MAX_BURST))) begin
                    if (can_write) begin
                        accept = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Release and re-arbitrate in the same cycle (no bubble).
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                    arb     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (arb && can_write && pick_vld) begin
            accept  = 1'b1;
            acc_id  = pick_idx;
            owner_d = pick_idx;
            cnt_d   = CNT_W'(1);
            if (MAX_BURST > 1) begin
                state_d = ST_BURST;
            end else begin
                last_d  = pick_idx;
                state_d = ST_IDLE;
            end
        end
        if (accept) begin
            o_ack[acc_id] = 1'b1;
        end
    end

    // Select the accepted requester's data lane.
    always_comb begin
        wsel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == acc_id) begin
                wsel = i_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Arbiter state; 'last' starts at the top index so requester 0 goes first.
    always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered FIFO write port; data and id hold when nothing is accepted.
    always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) begin
            o_wen_ctrl <= 1'b0;
            o_wdata    <= '0;
            o_grant_id <= '0;
        end else begin
            o_wen_ctrl <= accept;
            if (accept) begin
                o_wdata    <= wsel;
                o_grant_id <= acc_id;
            end
        end
    end

`ifdef FIFO_WARB_STALL_CNT_EN
    logic [NUM_REQ-1:0][STALL_W-1:0] stall_q;

    // Count cycles each requester waits without an ack, saturating.
    always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) begin
            stall_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (i_req[k] && !o_ack[k] && (stall_q[k] != '1)) begin
                    stall_q[k] <= stall_q[k] + STALL_W'(1);
                end
            end
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed vector table, reset corner sequence, random run against a queue-level model.
// Latency: expects acks same cycle, writes one cycle later.
// Backpressure: drives full/almost-full from a modelled FIFO and checks it never overflows.
module tb_fifo_write_arbiter;

    localparam int N     = 2;
    localparam int DW    = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 4;

    logic          i_clk;
    logic          i_rest_n;
    logic [N-1:0]  i_req;
    logic [N*DW-1:0] i_wdata;
    logic [N-1:0]  o_ack;
    logic          i_full;
    logic          i_almost_full;
    logic          o_wen_ctrl;
    logic [DW-1:0] o_wdata;
    logic          o_grant_id;
`ifdef FIFO_WARB_STALL_CNT_EN
    logic [N*16-1:0] o_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fifo_write_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .i_clk         (i_clk),
        .i_rest_n      (i_rest_n),
        .i_req         (i_req),
        .i_wdata       (i_wdata),
        .o_ack         (o_ack),
        .i_full        (i_full),
        .i_almost_full (i_almost_full),
        .o_wen_ctrl    (o_wen_ctrl),
        .o_wdata       (o_wdata),
        .o_grant_id    (o_grant_id)
`ifdef FIFO_WARB_STALL_CNT_EN
        ,
        .o_stall_cnt   (o_stall_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]    req;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          full;
        logic          af;
        logic [1:0]    ack;
        logic          wen;
        logic [DW-1:0] wd;
        logic          gid;
    } vec_t;

    vec_t tbl[24];

    // Random-phase model state: requesters, FIFO occupancy and arbitration.
    bit            rq_req[N];
    logic [DW-1:0] rq_d[N];
    int            occ;
    int            m_owner, m_served, m_last, m_gid;
    bit            m_wen;
    logic [DW-1:0] m_wd;
    logic [1:0]    e_ack;
    logic [1:0]    req_vec;
    bit            can, found, dut_wen;
    int            c, pop_pct;

    initial begin
        // Rows: inputs for one cycle, expected o_ack that cycle, and the
        // registered outputs produced by the previous row's accept.
        tbl[0]  = '{2'b11, 8'h10, 8'h20, 1'b0, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{2'b11, 8'h11, 8'h20, 1'b0, 1'b0, 2'b01, 1'b1, 8'h10, 1'b0};
        tbl[2]  = '{2'b11, 8'h12, 8'h20, 1'b0, 1'b0, 2'b01, 1'b1, 8'h11, 1'b0};
        tbl[3]  = '{2'b11, 8'h13, 8'h20, 1'b0, 1'b0, 2'b01, 1'b1, 8'h12, 1'b0};
        tbl[4]  = '{2'b11, 8'h14, 8'h20, 1'b0, 1'b0, 2'b10, 1'b1, 8'h13, 1'b0};
        tbl[5]  = '{2'b11, 8'h14, 8'h21, 1'b0, 1'b0, 2'b10, 1'b1, 8'h20, 1'b1};
        tbl[6]  = '{2'b11, 8'h14, 8'h22, 1'b0, 1'b0, 2'b10, 1'b1, 8'h21, 1'b1};
        tbl[7]  = '{2'b11, 8'h14, 8'h23, 1'b0, 1'b0, 2'b10, 1'b1, 8'h22, 1'b1};
        tbl[8]  = '{2'b11, 8'h14, 8'h24, 1'b0, 1'b0, 2'b01, 1'b1, 8'h23, 1'b1};
        tbl[9]  = '{2'b00, 8'h15, 8'h24, 1'b0, 1'b0, 2'b00, 1'b1, 8'h14, 1'b0};
        tbl[10] = '{2'b00, 8'h15, 8'h24, 1'b0, 1'b0, 2'b00, 1'b0, 8'h14, 1'b0};
        tbl[11] = '{2'b01, 8'h30, 8'h24, 1'b0, 1'b0, 2'b01, 1'b0, 8'h14, 1'b0};
        tbl[12] = '{2'b01, 8'h31, 8'h24, 1'b0, 1'b0, 2'b01, 1'b1, 8'h30, 1'b0};
        tbl[13] = '{2'b01, 8'h32, 8'h24, 1'b0, 1'b0, 2'b01, 1'b1, 8'h31, 1'b0};
        tbl[14] = '{2'b01, 8'h33, 8'h24, 1'b1, 1'b0, 2'b00, 1'b1, 8'h32, 1'b0};
        tbl[15] = '{2'b01, 8'h33, 8'h24, 1'b1, 1'b0, 2'b00, 1'b0, 8'h32, 1'b0};
        tbl[16] = '{2'b01, 8'h33, 8'h24, 1'b0, 1'b0, 2'b01, 1'b0, 8'h32, 1'b0};
        tbl[17] = '{2'b01, 8'h34, 8'h24, 1'b0, 1'b0, 2'b01, 1'b1, 8'h33, 1'b0};
        tbl[18] = '{2'b00, 8'h35, 8'h24, 1'b0, 1'b0, 2'b00, 1'b1, 8'h34, 1'b0};
        tbl[19] = '{2'b10, 8'h35, 8'h40, 1'b0, 1'b1, 2'b10, 1'b0, 8'h34, 1'b0};
        tbl[20] = '{2'b10, 8'h35, 8'h41, 1'b0, 1'b1, 2'b00, 1'b1, 8'h40, 1'b1};
        tbl[21] = '{2'b10, 8'h35, 8'h41, 1'b1, 1'b0, 2'b00, 1'b0, 8'h40, 1'b1};
        tbl[22] = '{2'b10, 8'h35, 8'h41, 1'b0, 1'b0, 2'b10, 1'b0, 8'h40, 1'b1};
        tbl[23] = '{2'b00, 8'h35, 8'h42, 1'b0, 1'b0, 2'b00, 1'b1, 8'h41, 1'b1};

        // Reset with both requesting: nothing acked, outputs cleared.
        i_rest_n = 1'b0;
        i_req = 2'b11;
        i_wdata = '0;
        i_full = 1'b0;
        i_almost_full = 1'b0;
        @(posedge i_clk);
        #1;
        chk("reset.ack", o_ack, 2'b00);
        chk("reset.wen", o_wen_ctrl, 1'b0);
        chk("reset.wdata", o_wdata, 8'h00);
        chk("reset.gid", o_grant_id, 1'b0);
        i_rest_n = 1'b1;

        for (int r = 0; r < 24; r++) begin
            i_req = tbl[r].req;
            i_wdata = {tbl[r].d1, tbl[r].d0};
            i_full = tbl[r].full;
            i_almost_full = tbl[r].af;
            @(negedge i_clk);
            chk($sformatf("tbl%0d.ack", r), o_ack, tbl[r].ack);
            chk($sformatf("tbl%0d.wen", r), o_wen_ctrl, tbl[r].wen);
            chk($sformatf("tbl%0d.wdata", r), o_wdata, tbl[r].wd);
            chk($sformatf("tbl%0d.gid", r), o_grant_id, tbl[r].gid);
            @(posedge i_clk);
            #1;
        end

        // Reset in the middle of requester 1's burst.
        i_full = 1'b0;
        i_almost_full = 1'b0;
        i_req = 2'b10;
        i_wdata = {8'h60, 8'h50};
        @(negedge i_clk);
        chk("mid.ack_first", o_ack, 2'b10);
        @(posedge i_clk);
        #1;
        i_req = 2'b11;
        i_wdata = {8'h61, 8'h50};
        @(negedge i_clk);
        chk("mid.ack_burst", o_ack, 2'b10);
        @(posedge i_clk);
        #1;
        chk("mid.wen_inflight", o_wen_ctrl, 1'b1);
        chk("mid.wdata_inflight", o_wdata, 8'h61);
        chk("mid.gid_inflight", o_grant_id, 1'b1);
        i_rest_n = 1'b0;
        #1;
        chk("mid.wen_reset", o_wen_ctrl, 1'b0);
        chk("mid.ack_reset", o_ack, 2'b00);
        chk("mid.wdata_reset", o_wdata, 8'h00);
        @(negedge i_clk);
        i_rest_n = 1'b1;
        #1;
        chk("mid.ack_restart", o_ack, 2'b01);
        @(posedge i_clk);
        #1;
        chk("mid.wen_restart", o_wen_ctrl, 1'b1);
        chk("mid.wdata_restart", o_wdata, 8'h50);
        chk("mid.gid_restart", o_grant_id, 1'b0);

`ifdef FIFO_WARB_STALL_CNT_EN
        // Requester 1 blocked by a full FIFO for ten edges.
        i_rest_n = 1'b0;
        i_req = 2'b00;
        i_full = 1'b0;
        #1;
        @(negedge i_clk);
        i_rest_n = 1'b1;
        i_req = 2'b10;
        i_full = 1'b1;
        repeat (10) @(posedge i_clk);
        #1;
        chk("stall.req1", o_stall_cnt[31:16], 16'd10);
        chk("stall.req0", o_stall_cnt[15:0], 16'd0);
`endif

        // Random run against the model.
        i_rest_n = 1'b0;
        i_req = 2'b00;
        i_full = 1'b0;
        i_almost_full = 1'b0;
        #1;
        @(negedge i_clk);
        i_rest_n = 1'b1;
        @(posedge i_clk);
        #1;
        for (int k = 0; k < N; k++) begin
            rq_req[k] = 1'b0;
            rq_d[k] = '0;
        end
        occ = 0;
        m_owner = -1;
        m_served = 0;
        m_last = N - 1;
        m_wen = 1'b0;
        m_wd = '0;
        m_gid = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            pop_pct = ((cyc / 500) % 2 == 1) ? 70 : 25;
            for (int k = 0; k < N; k++) begin
                req_vec[k] = rq_req[k];
            end
            i_req = req_vec;
            i_wdata = {rq_d[1], rq_d[0]};
            i_full = (occ == DEPTH);
            i_almost_full = (occ == DEPTH - 1);
            @(negedge i_clk);

            // Arbitration rules at the level of "who owns the port".
            can = !i_full && !(m_wen && i_almost_full);
            if (m_owner >= 0 && (!rq_req[m_owner] || m_served == MB)) begin
                m_last = m_owner;
                m_owner = -1;
            end
            if (m_owner < 0 && can) begin
                found = 1'b0;
                for (int j = 1; j <= N; j++) begin
                    c = (m_last + j) % N;
                    if (!found && rq_req[c]) begin
                        found = 1'b1;
                        m_owner = c;
                        m_served = 0;
                    end
                end
            end
            e_ack = 2'b00;
            if (m_owner >= 0 && can && rq_req[m_owner] && m_served < MB) begin
                e_ack = 2'(1 << m_owner);
                m_served++;
            end

            chk("rnd.ack", o_ack, e_ack);
            chk("rnd.wen", o_wen_ctrl, m_wen);
            chk("rnd.wdata", o_wdata, m_wd);
            chk("rnd.gid", o_grant_id, m_gid);
            dut_wen = o_wen_ctrl;

            @(posedge i_clk);
            if (dut_wen) begin
                checks++;
                if (occ >= DEPTH) begin
                    errors++;
                    $display("FAIL rnd.overflow: write with occupancy %0d, depth %0d", occ, DEPTH);
                end else begin
                    occ++;
                end
            end
            if (occ > 0 && $urandom_range(0, 99) < pop_pct) begin
                occ--;
            end
            if (e_ack != 2'b00) begin
                m_wen = 1'b1;
                m_wd = rq_d[m_owner];
                m_gid = m_owner;
            end else begin
                m_wen = 1'b0;
            end
            for (int k = 0; k < N; k++) begin
                if (e_ack[k]) begin
                    rq_d[k] = DW'($urandom);
                    rq_req[k] = ($urandom_range(0, 3) != 0);
                end else if (rq_req[k]) begin
                    if ($urandom_range(0, 15) == 0) begin
                        rq_req[k] = 1'b0;
                    end
                end else if ($urandom_range(0, 1) == 0) begin
                    rq_req[k] = 1'b1;
                    rq_d[k] = DW'($urandom);
                end
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
